addr_decode_cs_ws: RTL and testbench

//  Parametrised CPU address decoder / chip-select generator for the Konami

---
 rtl/addr_decode_cs_ws.sv | 133 +++++++++++++
 tb/tb_addr_decode_cs_ws.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/addr_decode_cs_ws.sv
// addr_decode_cs_ws: base/mask chip-select decoder with per-region wait states and req/ready handshake
//
// Ports:
//   clk      in   1      system clock, all state on posedge
//   rst_n    in   1      asynchronous active-low reset
//   addr     in   AW     CPU address, decoded on request acceptance
//   req      in   1      access request, held high until ready seen
//   rnw      in   1      1=read, 0=write
//   wdata    in   DW     write data (bank register)
//   cs_n     out  NCS    active-low one-hot chip selects (registered)
//   ready    out  1      access complete, held until req drops
//   nomatch  out  1      accepted access hit no region
//   bank     out  BANKW  bank register value
//
// Optional feature: define BANK_REG_EN to enable the bank register at BANK_ADDR.
// Without it, bank stays 0 and BANK_ADDR decodes through the regions.
module addr_decode_cs_ws #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int NCS = 4,
    parameter logic [NCS*AW-1:0] CS_BASE = {16'h2000, 16'h8000, 16'h4000, 16'h0000},
    parameter logic [NCS*AW-1:0] CS_MASK = {16'hF000, 16'h8000, 16'hC000, 16'hC000},
    parameter logic [NCS*4-1:0] CS_WS = {4'd3, 4'd1, 4'd2, 4'd0},
    parameter logic [AW-1:0] BANK_ADDR = 16'h1FE0,
    parameter int BANKW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    addr,
    input  logic             req,
    input  logic             rnw,
    input  logic [DW-1:0]    wdata,
    output logic [NCS-1:0]   cs_n,
    output logic             ready,
    output logic             nomatch,
    output logic [BANKW-1:0] bank
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [NCS-1:0] cs_q, cs_d, hit_oh;
    logic [3:0] cnt_q, cnt_d, hit_ws;
    logic ready_q, ready_d, nomatch_q, nomatch_d, hit, bank_hit;
    logic [BANKW-1:0] bank_q, bank_d;
    logic unused_in;
    assign unused_in = ^{wdata, BANK_ADDR};
`ifdef BANK_REG_EN
    assign bank_hit = !rnw && (addr == BANK_ADDR);
`else
    assign bank_hit = 1'b0;
`endif
    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_oh = '0;
        hit = 1'b0;
        hit_ws = 4'd0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if ((addr & CS_MASK[i*AW +: AW]) == (CS_BASE[i*AW +: AW] & CS_MASK[i*AW +: AW])) begin
                hit_oh = '0;
                hit_oh[i] = 1'b1;
                hit = 1'b1;
                hit_ws = CS_WS[i*4 +: 4];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cs_d = cs_q;
        cnt_d = cnt_q;
        ready_d = ready_q;
        nomatch_d = nomatch_q;
        bank_d = bank_q;
        case (state_q)
            IDLE: begin
                if (req && bank_hit) begin
                    bank_d = wdata[BANKW-1:0];
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (req && hit) begin
                    cs_d = ~hit_oh;
                    cnt_d = hit_ws;
                    state_d = WAIT;
                end else if (req) begin
                    nomatch_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                // Dropping req aborts, even on the cycle ready would have risen.
                if (!req) begin
                    cs_d = '1;
                    cnt_d = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!req) begin
                    cs_d = '1;
                    ready_d = 1'b0;
                    nomatch_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cs_q <= '1;
            cnt_q <= 4'd0;
            ready_q <= 1'b0;
            nomatch_q <= 1'b0;
            bank_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q <= cs_d;
            cnt_q <= cnt_d;
            ready_q <= ready_d;
            nomatch_q <= nomatch_d;
            bank_q <= bank_d;
        end
    end
    assign cs_n = cs_q;
    assign ready = ready_q;
    assign nomatch = nomatch_q;
    assign bank = bank_q;
endmodule

// File: tb/tb_addr_decode_cs_ws.sv
// tb_addr_decode_cs_ws: directed and random accesses checked against a region/timing model
module tb_addr_decode_cs_ws;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [15:0] addr = '0;
    logic req = 1'b0;
    logic rnw = 1'b1;
    logic [7:0] wdata = '0;
    logic [3:0] cs_n0, cs_n1;
    logic ready0, ready1, nomatch0, nomatch1;
    logic [4:0] bank0, bank1;
    int checks = 0;
    int failures = 0;
    logic [4:0] exp_bank = '0;
`ifdef BANK_REG_EN
    localparam bit BANK_EN = 1'b1;
`else
    localparam bit BANK_EN = 1'b0;
`endif
    logic [15:0] base [4] = '{16'h0000, 16'h4000, 16'h8000, 16'h2000};
    logic [15:0] mask [4] = '{16'hC000, 16'hC000, 16'h8000, 16'hF000};
    int ws [4] = '{0, 2, 1, 3};

    always #5 clk = ~clk;

    addr_decode_cs_ws u0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .req(req), .rnw(rnw), .wdata(wdata),
        .cs_n(cs_n0), .ready(ready0), .nomatch(nomatch0), .bank(bank0)
    );
    addr_decode_cs_ws #(.CS_MASK({16'hF000, 16'h8000, 16'hC000, 16'hE000})) u1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .req(req), .rnw(rnw), .wdata(wdata),
        .cs_n(cs_n1), .ready(ready1), .nomatch(nomatch1), .bank(bank1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Region index hit by address a (lowest wins), -1 if none; m0 is region 0's mask.
    function automatic int region(input logic [15:0] a, input logic [15:0] m0);
        logic [15:0] m;
        for (int i = 0; i < 4; i++) begin
            m = (i == 0) ? m0 : mask[i];
            if ((a & m) == (base[i] & m)) return i;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".cs0"}, {12'h0, cs_n0}, 16'hF);
        chk({tag, ".rdy0"}, {15'h0, ready0}, 16'h0);
        chk({tag, ".nm0"}, {15'h0, nomatch0}, 16'h0);
        chk({tag, ".cs1"}, {12'h0, cs_n1}, 16'hF);
        chk({tag, ".rdy1"}, {15'h0, ready1}, 16'h0);
        chk({tag, ".nm1"}, {15'h0, nomatch1}, 16'h0);
        chk({tag, ".bank"}, {11'h0, bank0}, {11'h0, exp_bank});
        chk({tag, ".bank1"}, {11'h0, bank1}, {11'h0, exp_bank});
    endtask

    // j = edges since acceptance; region accesses raise ready ws+1 edges in.
    task automatic chk_dut(input string tag, input int k, input logic bk, input int j,
                           input logic [3:0] cs, input logic rd, input logic nm, input logic [4:0] bo);
        logic [3:0] ecs;
        logic erd, enm;
        ecs = (k >= 0) ? (4'hF ^ (4'b1 << k)) : 4'hF;
        erd = (k >= 0) ? (j >= ws[k] + 1) : 1'b1;
        enm = (k < 0) && !bk;
        chk({tag, ".cs"}, {12'h0, cs}, {12'h0, ecs});
        chk({tag, ".rdy"}, {15'h0, rd}, {15'h0, erd});
        chk({tag, ".nm"}, {15'h0, nm}, {15'h0, enm});
        chk({tag, ".bank"}, {11'h0, bo}, {11'h0, exp_bank});
    endtask

    // Hold req for h samples after acceptance (scrambling addr/rnw/wdata), then drop it.
    task automatic access(input string tag, input logic [15:0] a, input logic r, input logic [7:0] w, input int h);
        int k0, k1;
        logic bk;
        bk = BANK_EN && !r && (a == 16'h1FE0);
        k0 = bk ? -1 : region(a, 16'hC000);
        k1 = bk ? -1 : region(a, 16'hE000);
        addr = a;
        rnw = r;
        wdata = w;
        req = 1'b1;
        if (bk) exp_bank = w[4:0];
        for (int j = 0; j < h; j++) begin
            @(posedge clk);
            #1;
            chk_dut({tag, ".u0"}, k0, bk, j, cs_n0, ready0, nomatch0, bank0);
            chk_dut({tag, ".u1"}, k1, bk, j, cs_n1, ready1, nomatch1, bank1);
            addr = 16'($urandom);
            rnw = 1'($urandom);
            wdata = 8'($urandom);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        chk_idle({tag, ".end"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("idle_noreq");
        addr = 16'h5000;
        req = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wait.cs", {12'h0, cs_n0}, 16'hD);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("rst_release");
        access("r0_ws0", 16'h0100, 1'b1, 8'h00, 3);
        access("r1_ws2", 16'h5000, 1'b1, 8'h00, 5);
        access("r1_abort", 16'h5000, 1'b1, 8'h00, 1);
        access("r1_abort_late", 16'h5000, 1'b1, 8'h00, 3);
        access("overlap", 16'h2800, 1'b1, 8'h00, 3);
        access("nomatch", 16'h3800, 1'b1, 8'h00, 2);
        access("bank_wr", 16'h1FE0, 1'b0, 8'h1B, 2);
        access("bank_rd", 16'h1FE0, 1'b1, 8'h00, 3);
        access("b2b_r2", 16'h9000, 1'b1, 8'h00, 4);
        access("r3_ws3", 16'h2F00, 1'b0, 8'h55, 6);
        for (int n = 0; n < 150; n++) begin
            int gap;
            logic [15:0] a;
            a = ($urandom_range(0, 7) == 0) ? 16'h1FE0 : 16'($urandom);
            access("rand", a, 1'($urandom), 8'($urandom), $urandom_range(1, 6));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                chk_idle("gap");
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
